// File: rtl/ssd1306_spi_framebuffer.sv
// rtl/ssd1306_spi_framebuffer.sv - SSD1306-compatible 4-wire SPI receiver, command decoder and 1024x8 GDDRAM
//
// Receives SSD1306 SPI traffic in the Clock domain, decodes the addressing and
// display command subset, stores data bytes into an 8-page x 128-column GDDRAM,
// and serves single pixels to the VGA timing stage with 1-cycle latency.
// Optional build macro: SSD1306_VERTICAL_MODE_EN (enables vertical addressing, mode 1).
//
// Ports:
//   Clock        system clock
//   Reset        asynchronous, active-low
//   SPI_SCK      SPI clock (mode 0, at most Clock/4)
//   SPI_MOSI     serial data, MSB first
//   SPI_CS       chip select, active-low
//   SPI_DC       0 = command byte, 1 = data byte
//   PixelX_i     pixel column 0..127
//   PixelY_i     pixel row 0..63
//   Pixel_o      pixel value for the (X,Y) presented on the previous cycle
//   DisplayOn_o  display-on flag
module ssd1306_spi_framebuffer #(
   parameter int SYNC_STAGES     = 2,
   parameter bit INIT_DISPLAY_ON = 1'b0
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       SPI_SCK,
   input  logic       SPI_MOSI,
   input  logic       SPI_CS,
   input  logic       SPI_DC,
   input  logic [6:0] PixelX_i,
   input  logic [5:0] PixelY_i,
   output logic       Pixel_o,
   output logic       DisplayOn_o
);

   typedef enum logic [1:0] {IDLE, ARG1, ARG2} state_t;

   logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync, dc_sync;
   logic       sck_prev;
   logic       sck_s, mosi_s, cs_s, dc_s, sck_rise;

   logic [2:0] bit_cnt;
   logic [6:0] shift;
   logic       byte_valid;
   logic [7:0] rx_byte;
   logic       rx_dc;
   logic       cmd_valid, data_valid;

   state_t     state, state_next;
   logic [7:0] opcode;
   logic [6:0] arg1;
   logic       display_on, invert;
   logic [1:0] mode;
   logic [6:0] col_start, col_end, col;
   logic [2:0] page_start, page_end, page;

   logic [7:0] gddram [0:1023];

   assign sck_s  = sck_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign dc_s   = dc_sync[SYNC_STAGES-1];
   assign sck_rise   = sck_s & ~sck_prev & ~cs_s;
   assign cmd_valid  = byte_valid & ~rx_dc;
   assign data_valid = byte_valid & rx_dc;
   assign DisplayOn_o = display_on;

   // CS resets to its idle (deasserted) level so nothing is received until the
   // host genuinely drives it low.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
         cs_sync   <= '1;
         dc_sync   <= '0;
         sck_prev  <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SPI_SCK};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
         dc_sync   <= {dc_sync[SYNC_STAGES-2:0], SPI_DC};
         sck_prev  <= sck_s;
      end
   end

   // Byte assembly; byte_valid is a one-cycle strobe the cycle after the 8th edge.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         bit_cnt    <= 3'd0;
         shift      <= 7'd0;
         byte_valid <= 1'b0;
         rx_byte    <= 8'd0;
         rx_dc      <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         if (cs_s) begin
            bit_cnt <= 3'd0;
         end else if (sck_rise) begin
            shift   <= {shift[5:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_valid <= 1'b1;
               rx_byte    <= {shift, mosi_s};
               rx_dc      <= dc_s;
            end
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (cs_s) begin
         state_next = IDLE;
      end else if (cmd_valid) begin
         case (state)
            IDLE:    if (rx_byte == 8'h20 || rx_byte == 8'h21 || rx_byte == 8'h22)
                        state_next = ARG1;
            ARG1:    state_next = (opcode == 8'h20) ? IDLE : ARG2;
            ARG2:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Two-argument commands hold arg1 aside and commit both bounds together, so
   // a transfer aborted by CS between arguments leaves the old window intact.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         opcode     <= 8'd0;
         arg1       <= 7'd0;
         display_on <= INIT_DISPLAY_ON;
         invert     <= 1'b0;
         mode       <= 2'd2;
         col_start  <= 7'd0;
         col_end    <= 7'd127;
         col        <= 7'd0;
         page_start <= 3'd0;
         page_end   <= 3'd7;
         page       <= 3'd0;
      end else if (cmd_valid) begin
         case (state)
            IDLE: begin
               opcode <= rx_byte;
               casez (rx_byte)
                  8'hAE:       display_on <= 1'b0;
                  8'hAF:       display_on <= 1'b1;
                  8'hA6:       invert     <= 1'b0;
                  8'hA7:       invert     <= 1'b1;
                  8'b1011_0???: page      <= rx_byte[2:0];
                  8'b0000_????: col[3:0]  <= rx_byte[3:0];
                  8'b0001_0???: col[6:4]  <= rx_byte[2:0];
                  default: ;
               endcase
            end
            ARG1: begin
               if (opcode == 8'h20) mode <= rx_byte[1:0];
               else                 arg1 <= rx_byte[6:0];
            end
            ARG2: begin
               if (opcode == 8'h21) begin
                  col_start <= arg1;
                  col_end   <= rx_byte[6:0];
                  col       <= arg1;
               end else begin
                  page_start <= arg1[2:0];
                  page_end   <= rx_byte[2:0];
                  page       <= arg1[2:0];
               end
            end
            default: ;
         endcase
      end else if (data_valid) begin
         if (mode == 2'd0) begin
            if (col == col_end) begin
               col  <= col_start;
               page <= (page == page_end) ? page_start : page + 3'd1;
            end else begin
               col <= col + 7'd1;
            end
`ifdef SSD1306_VERTICAL_MODE_EN
         end else if (mode == 2'd1) begin
            if (page == page_end) begin
               page <= page_start;
               col  <= (col == col_end) ? col_start : col + 7'd1;
            end else begin
               page <= page + 3'd1;
            end
`endif
         end else begin
            col <= col + 7'd1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (data_valid) gddram[{page, col}] <= rx_byte;
   end

   // Read-first: the non-blocking write above lands after this read.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) Pixel_o <= 1'b0;
      else        Pixel_o <= display_on &
                             (gddram[{PixelY_i[5:3], PixelX_i}][PixelY_i[2:0]] ^ invert);
   end

endmodule

// File: tb/tb_ssd1306_spi_framebuffer.sv
// tb/tb_ssd1306_spi_framebuffer.sv - directed table-driven bench for ssd1306_spi_framebuffer
module tb_ssd1306_spi_framebuffer;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       SPI_SCK = 1'b0, SPI_MOSI = 1'b0, SPI_CS = 1'b1, SPI_DC = 1'b0;
   logic [6:0] PixelX_i = '0;
   logic [5:0] PixelY_i = '0;
   logic       Pixel_o, DisplayOn_o;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {
      int         phase;
      logic [2:0] page;
      logic [6:0] col;
      logic [7:0] expected;
   } vec_t;

   vec_t vecs[$];

   ssd1306_spi_framebuffer dut (
      .Clock(Clock), .Reset(Reset),
      .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI), .SPI_CS(SPI_CS), .SPI_DC(SPI_DC),
      .PixelX_i(PixelX_i), .PixelY_i(PixelY_i),
      .Pixel_o(Pixel_o), .DisplayOn_o(DisplayOn_o)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
      total_cnt++;
      if (actual === expected) pass_cnt++;
      else $display("FAIL %s: got %02h expected %02h", name, actual, expected);
   endtask

   task automatic spi_bits(input logic dc, input logic [7:0] b, input int n);
      SPI_DC = dc;
      for (int i = 7; i > 7 - n; i--) begin
         SPI_MOSI = b[i];
         #40 SPI_SCK = 1'b1;
         #40 SPI_SCK = 1'b0;
      end
      #100;
   endtask

   task automatic spi_byte(input logic dc, input logic [7:0] b);
      spi_bits(dc, b, 8);
   endtask

   task automatic cs_pulse();
      SPI_CS = 1'b1;
      #100;
      SPI_CS = 1'b0;
      #100;
   endtask

   task automatic read_byte(input logic [2:0] page, input logic [6:0] col, output logic [7:0] b);
      for (int r = 0; r < 8; r++) begin
         PixelX_i = col;
         PixelY_i = {page, r[2:0]};
         @(posedge Clock);
         #1 b[r] = Pixel_o;
      end
   endtask

   task automatic check_phase(input int p);
      logic [7:0] b;
      foreach (vecs[i]) begin
         if (vecs[i].phase == p) begin
            read_byte(vecs[i].page, vecs[i].col, b);
            check($sformatf("ph%0d pg%0d col%0d", p, vecs[i].page, vecs[i].col), b, vecs[i].expected);
         end
      end
   endtask

   initial begin
      vecs.push_back('{1, 3'd2, 7'd53, 8'h81});
      vecs.push_back('{2, 3'd6, 7'd126, 8'h04});
      vecs.push_back('{2, 3'd6, 7'd127, 8'h01});
      vecs.push_back('{2, 3'd7, 7'd126, 8'h02});
      vecs.push_back('{2, 3'd7, 7'd127, 8'h03});
      vecs.push_back('{3, 3'd3, 7'd127, 8'hAA});
      vecs.push_back('{3, 3'd3, 7'd0, 8'h55});
      vecs.push_back('{3, 3'd3, 7'd1, 8'h66});
      vecs.push_back('{4, 3'd3, 7'd127, 8'h55});
      vecs.push_back('{4, 3'd7, 7'd127, 8'hEE});
      vecs.push_back('{4, 3'd6, 7'd126, 8'hDD});
      vecs.push_back('{5, 3'd6, 7'd126, 8'h22});
`ifdef SSD1306_VERTICAL_MODE_EN
      vecs.push_back('{6, 3'd0, 7'd10, 8'h05});
      vecs.push_back('{6, 3'd1, 7'd10, 8'h02});
      vecs.push_back('{6, 3'd0, 7'd11, 8'h03});
      vecs.push_back('{6, 3'd1, 7'd11, 8'h04});
`else
      vecs.push_back('{6, 3'd0, 7'd10, 8'h01});
      vecs.push_back('{6, 3'd0, 7'd11, 8'h02});
      vecs.push_back('{6, 3'd0, 7'd12, 8'h03});
      vecs.push_back('{6, 3'd0, 7'd13, 8'h04});
      vecs.push_back('{6, 3'd0, 7'd14, 8'h05});
`endif
      vecs.push_back('{7, 3'd6, 7'd126, 8'h00});

      // Reset state, then reset mid-byte must discard the partial byte.
      #33;
      check("reset displayon", {7'd0, DisplayOn_o}, 8'h00);
      check("reset pixel", {7'd0, Pixel_o}, 8'h00);
      Reset = 1'b1;
      #50 SPI_CS = 1'b0;
      #100;
      spi_bits(1'b0, 8'hA5, 4);
      Reset = 1'b0;
      #30;
      check("midreset displayon", {7'd0, DisplayOn_o}, 8'h00);
      Reset = 1'b1;
      #50;
      spi_byte(1'b0, 8'hAF);
      check("after AF displayon", {7'd0, DisplayOn_o}, 8'h01);

      // Page/column set commands and the 1-cycle read latency.
      spi_byte(1'b0, 8'hB2);
      spi_byte(1'b0, 8'h05);
      spi_byte(1'b0, 8'h13);
      spi_byte(1'b1, 8'h81);
      begin
         logic [5:0] ys [3];
         logic [7:0] ex [3];
         ys[0] = 6'd16; ys[1] = 6'd17; ys[2] = 6'd23;
         ex[0] = 8'h01; ex[1] = 8'h00; ex[2] = 8'h01;
         @(posedge Clock);
         #1;
         for (int i = 0; i < 3; i++) begin
            PixelX_i = 7'd53;
            PixelY_i = ys[i];
            @(posedge Clock);
            #1 check($sformatf("pix y%0d", ys[i]), {7'd0, Pixel_o}, ex[i]);
         end
      end
      check_phase(1);

      // Horizontal mode with a 2x2 window, wrapping back to the window start.
      spi_byte(1'b0, 8'h20); spi_byte(1'b0, 8'h00);
      spi_byte(1'b0, 8'h21); spi_byte(1'b0, 8'd126); spi_byte(1'b0, 8'd127);
      spi_byte(1'b0, 8'h22); spi_byte(1'b0, 8'd6); spi_byte(1'b0, 8'd7);
      spi_byte(1'b1, 8'hFF); spi_byte(1'b1, 8'h01); spi_byte(1'b1, 8'h02);
      spi_byte(1'b1, 8'h03); spi_byte(1'b1, 8'h04);
      check_phase(2);

      // Page mode column wrap 127 -> 0 without page change.
      spi_byte(1'b0, 8'h20); spi_byte(1'b0, 8'h02);
      spi_byte(1'b0, 8'hB3); spi_byte(1'b0, 8'h0F); spi_byte(1'b0, 8'h17);
      spi_byte(1'b1, 8'hAA); spi_byte(1'b1, 8'h55); spi_byte(1'b1, 8'h66);
      check_phase(3);

      // CS abort between arguments of 0x22; next byte decodes as a fresh command.
      spi_byte(1'b0, 8'h22); spi_byte(1'b0, 8'h00);
      cs_pulse();
      spi_byte(1'b0, 8'hA7);
      spi_byte(1'b0, 8'h20); spi_byte(1'b0, 8'h00);
      spi_byte(1'b0, 8'hB7); spi_byte(1'b0, 8'h0F); spi_byte(1'b0, 8'h17);
      spi_byte(1'b1, 8'h11); spi_byte(1'b1, 8'h22);
      check_phase(4);
      spi_byte(1'b0, 8'hA6);
      check_phase(5);

      // Mode 1: vertical with the macro, page-mode behaviour without it.
      spi_byte(1'b0, 8'h20); spi_byte(1'b0, 8'h01);
      spi_byte(1'b0, 8'h21); spi_byte(1'b0, 8'd10); spi_byte(1'b0, 8'd11);
      spi_byte(1'b0, 8'h22); spi_byte(1'b0, 8'd0); spi_byte(1'b0, 8'd1);
      for (int d = 1; d <= 5; d++) spi_byte(1'b1, d[7:0]);
      check_phase(6);

      // Display off forces pixels low.
      spi_byte(1'b0, 8'hAE);
      check("after AE displayon", {7'd0, DisplayOn_o}, 8'h00);
      check_phase(7);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
